// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronizes and glitch-filters encoder phases A/B, then
// turns each legal Gray-code transition into a step pulse and a wrapping position count.
//
// state | meaning
// ------+------------------------------------------------------------
// INIT  | hold-off after reset; prev tracks filtered inputs, no decode
// RUN   | decode transitions into count/dir/step, flag illegal moves
module quad_decoder #(
    parameter int CNT_W    = 4,
    parameter int FILT_LEN = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             dir,
    output logic             step,
    output logic             err
);

    typedef enum logic {INIT, RUN} state_t;

    localparam int              HOLD_W    = 5;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(FILT_LEN + 2);
    localparam logic [3:0]      FILT_TC   = 4'(FILT_LEN - 1);

    // Phase vectors are packed {A, B}.
    logic [1:0]      s1, s2, filt, prev;
    logic [1:0][3:0] fcnt;

    state_t            state, state_nxt;
    logic [HOLD_W-1:0] hold, hold_nxt;
    logic [CNT_W-1:0]  count_nxt;
    logic              dir_nxt, step_nxt, err_nxt;
    logic [1:0]        moved;
    logic              up;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= {enc_a, enc_b};
            s2 <= s1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt <= '0;
            fcnt <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FILT_TC) begin
                    filt[i] <= s2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= INIT;
            hold  <= HOLD_INIT;
            prev  <= '0;
            count <= '0;
            dir   <= 1'b1;
            step  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            hold  <= hold_nxt;
            prev  <= filt;
            count <= count_nxt;
            dir   <= dir_nxt;
            step  <= step_nxt;
            err   <= err_nxt;
        end
    end

    // For a single-bit Gray move, the step is "up" exactly when old A differs from new B.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold;
        count_nxt = count;
        dir_nxt   = dir;
        step_nxt  = 1'b0;
        err_nxt   = err;
        moved     = prev ^ filt;
        up        = prev[1] ^ filt[0];

        case (state)
            INIT: begin
                if (hold == '0) state_nxt = RUN;
                else            hold_nxt  = hold - 1'b1;
            end
            RUN: begin
                if (moved == 2'b11) begin
                    err_nxt = 1'b1;
                end else if (moved != 2'b00) begin
                    step_nxt = 1'b1;
                    dir_nxt  = up;
                    if (up) count_nxt = count + 1'b1;
                    else    count_nxt = count - 1'b1;
                end
            end
            default: state_nxt = INIT;
        endcase

        if (clr) begin
            count_nxt = '0;
            err_nxt   = 1'b0;
            step_nxt  = 1'b0;
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: table of encoder levels plus hand sequences; a step
// monitor pops expected {dir,count} from a scoreboard queue on every step pulse.
module tb_quad_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       enc_a, enc_b, clr;
    logic [3:0] count;
    logic       dir, step, err;

    int total = 0;
    int bad   = 0;
    int pulses = 0;
    int p0;
    logic       step_prev = 1'b0;
    logic [4:0] sb_e;
    logic [4:0] exp_q[$];

    typedef struct {
        logic       a;
        logic       b;
        int         hold;
        logic [3:0] exp_count;
        logic       exp_dir;
        logic       exp_err;
    } vec_t;

    vec_t       vecs[16];
    logic [1:0] up_seq[4];

    quad_decoder #(.CNT_W(4), .FILT_LEN(3)) dut (
        .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b), .clr(clr),
        .count(count), .dir(dir), .step(step), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_ab(input logic [1:0] ab);
        enc_a = ab[1];
        enc_b = ab[0];
    endtask

    task automatic push_exp(input logic d, input logic [3:0] c);
        exp_q.push_back({d, c});
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (step) begin
                pulses++;
                check("step_one_cycle", step_prev, 0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_step: count=%0d dir=%0d, nothing expected", count, dir);
                end else begin
                    sb_e = exp_q.pop_front();
                    check("sb_count", count, sb_e[3:0]);
                    check("sb_dir", dir, sb_e[4]);
                end
            end
            step_prev = step;
        end else begin
            step_prev = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        up_seq[0] = 2'b01; up_seq[1] = 2'b11; up_seq[2] = 2'b10; up_seq[3] = 2'b00;
        for (int i = 0; i < 16; i++) begin
            vecs[i].a         = up_seq[i % 4][1];
            vecs[i].b         = up_seq[i % 4][0];
            vecs[i].hold      = 10;
            vecs[i].exp_count = 4'((i + 1) % 16);
            vecs[i].exp_dir   = 1'b1;
            vecs[i].exp_err   = 1'b0;
        end

        rst = 1'b0; clr = 1'b0; set_ab(2'b00);
        wait_cyc(3);
        check("rst_count", count, 0);
        check("rst_dir", dir, 1);
        check("rst_step", step, 0);
        check("rst_err", err, 0);
        rst = 1'b1;
        wait_cyc(12);
        check("init_count", count, 0);
        check("init_err", err, 0);

        // Up sequence 4x with wrap
        p0 = pulses;
        for (int i = 0; i < 16; i++) begin
            set_ab({vecs[i].a, vecs[i].b});
            push_exp(vecs[i].exp_dir, vecs[i].exp_count);
            wait_cyc(vecs[i].hold);
            check("tbl_count", count, vecs[i].exp_count);
            check("tbl_dir", dir, vecs[i].exp_dir);
            check("tbl_err", err, vecs[i].exp_err);
        end
        check("up_pulses", pulses - p0, 16);

        // Down step latency: change before edge k, result at edge k+5
        set_ab(2'b10);
        push_exp(1'b0, 4'd15);
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        check("lat_k4_count", count, 0);
        check("lat_k4_step", step, 0);
        @(posedge clk);
        #1;
        check("lat_k5_count", count, 15);
        check("lat_k5_dir", dir, 0);
        check("lat_k5_step", step, 1);
        @(posedge clk);
        #1;
        check("lat_k6_step", step, 0);
        @(negedge clk);
        wait_cyc(5);

        // Glitch rejection
        set_ab(2'b00);
        push_exp(1'b1, 4'd0);
        wait_cyc(10);
        check("gl_base_count", count, 0);
        p0 = pulses;
        enc_a = 1'b1; wait_cyc(2); enc_a = 1'b0;
        wait_cyc(10);
        check("gl2_count", count, 0);
        check("gl2_err", err, 0);
        enc_a = 1'b1; wait_cyc(1); enc_a = 1'b0;
        wait_cyc(10);
        check("gl1_count", count, 0);
        check("gl_pulses", pulses - p0, 0);
        push_exp(1'b0, 4'd15);
        push_exp(1'b1, 4'd0);
        enc_a = 1'b1; wait_cyc(3); enc_a = 1'b0;
        wait_cyc(12);
        check("gl3_count", count, 0);
        check("gl3_pulses", pulses - p0, 2);

        // Illegal transition, then clr
        set_ab(2'b01); push_exp(1'b1, 4'd1); wait_cyc(10);
        set_ab(2'b11); push_exp(1'b1, 4'd2); wait_cyc(10);
        set_ab(2'b00); wait_cyc(10);
        check("ill_err", err, 1);
        check("ill_count", count, 2);
        check("ill_dir", dir, 1);
        check("ill_step", step, 0);
        clr = 1'b1; wait_cyc(1); clr = 1'b0;
        check("clr_count", count, 0);
        check("clr_err", err, 0);

        // clr landing on the same edge as an up step
        for (int i = 0; i < 7; i++) begin
            set_ab(up_seq[i % 4]);
            push_exp(1'b1, 4'(i + 1));
            wait_cyc(10);
        end
        check("pre_col_count", count, 7);
        set_ab(2'b00);
        @(posedge clk);
        repeat (4) @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        check("col_count", count, 0);
        check("col_step", step, 0);
        wait_cyc(5);
        set_ab(2'b01); push_exp(1'b1, 4'd1); wait_cyc(10);
        check("post_col_count", count, 1);

        // Stale level across reset, then async reset mid-filter
        rst = 1'b0;
        set_ab(2'b11);
        wait_cyc(3);
        check("rst2_count", count, 0);
        rst = 1'b1;
        p0 = pulses;
        wait_cyc(12);
        check("stale_err", err, 0);
        check("stale_count", count, 0);
        check("stale_pulses", pulses - p0, 0);
        set_ab(2'b10); push_exp(1'b1, 4'd1); wait_cyc(10);
        check("r_up_count", count, 1);
        set_ab(2'b11); push_exp(1'b0, 4'd0); wait_cyc(10);
        set_ab(2'b01); push_exp(1'b0, 4'd15); wait_cyc(10);
        check("r_dn_count", count, 15);
        check("r_dn_dir", dir, 0);
        set_ab(2'b00);
        wait_cyc(2);
        #3;
        rst = 1'b0;
        #1;
        check("async_count", count, 0);
        check("async_dir", dir, 1);
        check("async_step", step, 0);
        check("async_err", err, 0);
        @(negedge clk);
        rst = 1'b1;
        wait_cyc(15);
        check("final_count", count, 0);
        check("final_err", err, 0);
        check("sb_left", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
